// File: rtl/param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_pkg
// Description : Shared parameters and types for the coherence directory
//               storage (operation codes, geometry, directory entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package param_pkg;

    localparam int N_CPU              = 4;
    localparam int CPU_ID_WIDTH       = 3;
    localparam int DCACHE_TAG_WIDTH   = 8;
    localparam int DCACHE_INDEX_WIDTH = 4;

    typedef enum logic [2:0] {
        READ_OP     = 3'd0,
        ADD_OP      = 3'd1,
        REMOVE_OP   = 3'd2,
        SET_EXCL_OP = 3'd3,
        CLEAR_OP    = 3'd4
    } op_dir_t;

    typedef struct packed {
        logic                        valid;
        logic [DCACHE_TAG_WIDTH-1:0] tag;
        logic [N_CPU-1:0]            sharers;
    } dir_entry_t;

    // One-hot sharer bit for a CPU; ids outside the system map to no bit.
    function automatic logic [N_CPU-1:0] cpu_onehot(input logic [CPU_ID_WIDTH-1:0] id);
        logic [N_CPU-1:0] mask;
        mask = '0;
        if (id < CPU_ID_WIDTH'(N_CPU)) begin
            mask = N_CPU'(1) << id;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : dir_mem_array
// Description : Direct-mapped directory storage. One synchronous read port
//               (1-cycle latency), one write port. Only the valid bits are
//               reset; tag and sharer fields power up undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module dir_mem_array
    import param_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rd_en_i,
    input  logic [DCACHE_INDEX_WIDTH-1:0] rd_idx_i,
    input  logic                          wr_en_i,
    input  logic [DCACHE_INDEX_WIDTH-1:0] wr_idx_i,
    input  dir_entry_t                    wr_entry_i,
    output dir_entry_t                    rd_entry_o
);

    localparam int DEPTH = 2 ** DCACHE_INDEX_WIDTH;

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DCACHE_TAG_WIDTH-1:0] tag_mem   [DEPTH];
    logic [N_CPU-1:0]            sharer_mem[DEPTH];
    dir_entry_t                  rd_entry_q;
    dir_entry_t                  rd_entry_d;

    // Next valid vector and read-data capture.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_entry_i.valid;
        end
        rd_entry_d = rd_entry_q;
        if (rd_en_i) begin
            rd_entry_d.valid   = valid_q[rd_idx_i];
            rd_entry_d.tag     = tag_mem[rd_idx_i];
            rd_entry_d.sharers = sharer_mem[rd_idx_i];
        end
    end

    // Valid bits and read register are cleared by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q    <= '0;
            rd_entry_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    // Tag/sharer payload storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]    <= wr_entry_i.tag;
            sharer_mem[wr_idx_i] <= wr_entry_i.sharers;
        end
    end

    assign rd_entry_o = rd_entry_q;

endmodule
`default_nettype wire

// File: rtl/dir_mem.sv
`default_nettype none
// ============================================================================
// Module      : dir_mem
// Description : Coherence directory read-modify-write engine. Takes one
//               arbitrated request, looks up the direct-mapped entry,
//               applies the operation, and returns a one-cycle ack with the
//               pre-update sharers plus any eviction.
//               Optional macro DIR_MEM_STATS_EN adds saturating hit/miss/evict
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dir_mem
    import param_pkg::*;
#(
    parameter int STATS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          valid_i,
    input  op_dir_t                       op_i,
    input  logic [DCACHE_TAG_WIDTH-1:0]   tag_i,
    input  logic [DCACHE_INDEX_WIDTH-1:0] index_i,
    input  logic [CPU_ID_WIDTH-1:0]       cpu_id_i,
    output logic                          ack_o,
    output logic [N_CPU-1:0]              sharers_o,
    output logic                          hit_o,
    output logic                          evict_valid_o,
    output logic [DCACHE_TAG_WIDTH-1:0]   evict_tag_o,
    output logic [N_CPU-1:0]              evict_sharers_o,
    output logic                          busy_o
`ifdef DIR_MEM_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]        stat_hit_o,
    output logic [STATS_WIDTH-1:0]        stat_miss_o,
    output logic [STATS_WIDTH-1:0]        stat_evict_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    logic [1:0]                    state_q, state_d;
    op_dir_t                       op_q, op_d;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [DCACHE_INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [CPU_ID_WIDTH-1:0]       cpu_q, cpu_d;
    logic                          hit_q, hit_d;
    logic [N_CPU-1:0]              sharers_q, sharers_d;
    logic                          evict_q, evict_d;
    dir_entry_t                    old_q, old_d;
    dir_entry_t                    new_q, new_d;
    logic                          wr_q, wr_d;

    dir_entry_t                    rd_entry;
    dir_entry_t                    new_w;
    logic                          hit_w;
    logic                          evict_w;
    logic [N_CPU-1:0]              bit_w;
    logic                          ack_w;

    dir_mem_array u_array (
        .clk        (clk),
        .resetn     (resetn),
        .rd_en_i    ((state_q == ST_IDLE) && valid_i),
        .rd_idx_i   (index_i),
        .wr_en_i    ((state_q == ST_UPDATE) && wr_q),
        .wr_idx_i   (idx_q),
        .wr_entry_i (new_q),
        .rd_entry_o (rd_entry)
    );

    // Apply the captured operation to the entry returned by the array.
    always_comb begin
        bit_w   = cpu_onehot(cpu_q);
        hit_w   = rd_entry.valid && (rd_entry.tag == tag_q);
        new_w   = rd_entry;
        evict_w = 1'b0;
        case (op_q)
            ADD_OP: begin
                if (hit_w) begin
                    new_w.sharers = rd_entry.sharers | bit_w;
                end else begin
                    new_w   = '{valid: 1'b1, tag: tag_q, sharers: bit_w};
                    evict_w = rd_entry.valid;
                end
            end
            REMOVE_OP: begin
                if (hit_w) begin
                    new_w.sharers = rd_entry.sharers & ~bit_w;
                    if ((rd_entry.sharers & ~bit_w) == '0) begin
                        new_w.valid = 1'b0;
                    end
                end
            end
            SET_EXCL_OP: begin
                new_w   = '{valid: 1'b1, tag: tag_q, sharers: bit_w};
                evict_w = rd_entry.valid && !hit_w;
            end
            CLEAR_OP: begin
                if (hit_w) begin
                    new_w.valid = 1'b0;
                end
            end
            default: ;
        endcase
        // A requester outside the system may look but never modify.
        if (cpu_q >= CPU_ID_WIDTH'(N_CPU)) begin
            new_w   = rd_entry;
            evict_w = 1'b0;
        end
    end

    // Request FSM: capture in IDLE, resolve in LOOKUP, write/ack in UPDATE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        cpu_d     = cpu_q;
        hit_d     = hit_q;
        sharers_d = sharers_q;
        evict_d   = evict_q;
        old_d     = old_q;
        new_d     = new_q;
        wr_d      = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    op_d    = op_i;
                    tag_d   = tag_i;
                    idx_d   = index_i;
                    cpu_d   = cpu_id_i;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d     = hit_w;
                sharers_d = hit_w ? rd_entry.sharers : '0;
                evict_d   = evict_w;
                old_d     = rd_entry;
                new_d     = new_w;
                wr_d      = (new_w != rd_entry);
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                wr_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                wr_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            op_q      <= READ_OP;
            tag_q     <= '0;
            idx_q     <= '0;
            cpu_q     <= '0;
            hit_q     <= 1'b0;
            sharers_q <= '0;
            evict_q   <= 1'b0;
            old_q     <= '0;
            new_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            idx_q     <= idx_d;
            cpu_q     <= cpu_d;
            hit_q     <= hit_d;
            sharers_q <= sharers_d;
            evict_q   <= evict_d;
            old_q     <= old_d;
            new_q     <= new_d;
            wr_q      <= wr_d;
        end
    end

    assign ack_w           = (state_q == ST_UPDATE);
    assign ack_o           = ack_w;
    assign busy_o          = (state_q != ST_IDLE);
    assign hit_o           = ack_w & hit_q;
    assign sharers_o       = ack_w ? sharers_q : '0;
    assign evict_valid_o   = ack_w & evict_q;
    assign evict_tag_o     = (ack_w && evict_q) ? old_q.tag : '0;
    assign evict_sharers_o = (ack_w && evict_q) ? old_q.sharers : '0;

`ifdef DIR_MEM_STATS_EN
    logic [STATS_WIDTH-1:0] stat_hit_q, stat_hit_d;
    logic [STATS_WIDTH-1:0] stat_miss_q, stat_miss_d;
    logic [STATS_WIDTH-1:0] stat_evict_q, stat_evict_d;

    // Saturating counters advanced once per acknowledged request.
    always_comb begin
        stat_hit_d   = stat_hit_q;
        stat_miss_d  = stat_miss_q;
        stat_evict_d = stat_evict_q;
        if (ack_w) begin
            if (hit_q) begin
                if (!(&stat_hit_q)) stat_hit_d = stat_hit_q + 1'b1;
            end else begin
                if (!(&stat_miss_q)) stat_miss_d = stat_miss_q + 1'b1;
            end
            if (evict_q && !(&stat_evict_q)) begin
                stat_evict_d = stat_evict_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_hit_q   <= '0;
            stat_miss_q  <= '0;
            stat_evict_q <= '0;
        end else begin
            stat_hit_q   <= stat_hit_d;
            stat_miss_q  <= stat_miss_d;
            stat_evict_q <= stat_evict_d;
        end
    end

    assign stat_hit_o   = stat_hit_q;
    assign stat_miss_o  = stat_miss_q;
    assign stat_evict_o = stat_evict_q;
`else
    logic unused_stats_width;
    assign unused_stats_width = (STATS_WIDTH > 0);
`endif

endmodule
`default_nettype wire
